// File: rtl/dummy_dac.sv
// Playback stand-in for an absent DAC: drains the slot FIFO at a fixed tick rate
// and assembles little-endian 32-bit words. Checker enabled by DUMMY_DAC_CHECK_EN.
module dummy_dac #(
  parameter int          CLK_DIV  = 256,
  parameter logic [31:0] EXPECTED = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  output logic        fifo_clk,
  output logic        fifo_read,
  input  logic [7:0]  fifo_data,
  input  logic [10:0] fifo_addr_in,
  input  logic [10:0] fifo_addr_out,
  input  logic [5:0]  slot_data,
  input  logic        direction,
  input  logic        channels,
  output logic [31:0] sample,
  output logic        sample_valid,
  output logic [15:0] underrun_count,
  output logic [15:0] error_count,
  output logic        locked
);
  localparam int DIV_W = $clog2(CLK_DIV);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t             state, state_nx;
  logic [DIV_W-1:0]   div_cnt;
  logic               tick;
  logic [10:0]        level;
  logic [3:0]         need_now, need_r;
  logic [2:0]         rd_cnt;
  logic               start, short;
  logic               rd_vld;
  logic [1:0]         byte_idx;
  logic [23:0]        word_buf;
  logic               word_done;
  logic [31:0]        word_nx;
  logic               unused;

  assign fifo_clk = clk;
  assign unused   = ^{slot_data, EXPECTED};

  assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || tick) div_cnt <= '0;
    else               div_cnt <= div_cnt + 1'b1;
  end

  assign level    = fifo_addr_in - fifo_addr_out;
  assign need_now = channels ? 4'd8 : 4'd4;

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    short    = 1'b0;
    case (state)
      IDLE: begin
        if (tick && !direction) begin
          if (level >= {7'd0, need_now}) begin
            state_nx = READ;
            start    = 1'b1;
          end else begin
            short = 1'b1;
          end
        end
      end
      READ:    if (rd_cnt == 3'(need_r - 4'd1)) state_nx = DRAIN;
      DRAIN:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign fifo_read = (state == READ);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      need_r <= 4'd4;
      rd_cnt <= '0;
    end else begin
      state <= state_nx;
      if (start) begin
        need_r <= need_now;
        rd_cnt <= '0;
      end else if (state == READ) begin
        rd_cnt <= rd_cnt + 3'd1;
      end
    end
  end

  // Data arrives one cycle after the strobe; the fourth byte goes straight into sample.
  assign word_done = rd_vld && (byte_idx == 2'd3);
  assign word_nx   = {fifo_data, word_buf};

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld       <= 1'b0;
      byte_idx     <= '0;
      word_buf     <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      rd_vld       <= fifo_read;
      sample_valid <= 1'b0;
      if (rd_vld) begin
        byte_idx <= byte_idx + 2'd1;
        if (word_done) begin
          sample       <= word_nx;
          sample_valid <= 1'b1;
        end else begin
          word_buf[8*byte_idx +: 8] <= fifo_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                                  underrun_count <= '0;
    else if (short && underrun_count != 16'hFFFF) underrun_count <= underrun_count + 16'd1;
  end

`ifdef DUMMY_DAC_CHECK_EN
  logic [2:0] streak;

  always_ff @(posedge clk) begin
    if (reset) begin
      streak      <= '0;
      error_count <= '0;
    end else if (word_done) begin
      if (word_nx != EXPECTED) begin
        streak <= '0;
        if (error_count != 16'hFFFF) error_count <= error_count + 16'd1;
      end else if (streak != 3'd4) begin
        streak <= streak + 3'd1;
      end
    end
  end

  assign locked = (streak == 3'd4);
`else
  assign error_count = '0;
  assign locked      = 1'b0;
`endif

endmodule

// File: tb/tb_dummy_dac.sv
// Directed bench for dummy_dac: table of transfers plus reset and saturation sequences.
module tb_dummy_dac;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fifo_clk, fifo_read;
  logic [7:0]  fifo_data = 8'h00;
  logic [10:0] fifo_addr_in = 11'd0, fifo_addr_out;
  logic [5:0]  slot_data = 6'h2A;
  logic        direction = 1'b1, channels = 1'b0;
  logic [31:0] sample;
  logic        sample_valid, locked;
  logic [15:0] underrun_count, error_count;

  always #5 clk = ~clk;

  dummy_dac #(.CLK_DIV(16), .EXPECTED(32'hDEADBEEF)) dut (
    .clk(clk), .reset(reset), .fifo_clk(fifo_clk), .fifo_read(fifo_read),
    .fifo_data(fifo_data), .fifo_addr_in(fifo_addr_in), .fifo_addr_out(fifo_addr_out),
    .slot_data(slot_data), .direction(direction), .channels(channels),
    .sample(sample), .sample_valid(sample_valid), .underrun_count(underrun_count),
    .error_count(error_count), .locked(locked)
  );

  // FIFO model: read pointer advances with each strobe, data one cycle later
  logic [7:0]  mem [0:7];
  logic [10:0] nread = 11'd0, base_out = 11'd0;
  logic        clr = 1'b0;
  logic [3:0]  mcnt = 4'd0;

  assign fifo_addr_out = base_out + nread;

  always @(posedge clk) begin
    if (clr) nread <= 11'd0;
    else if (fifo_read) nread <= nread + 11'd1;
    if (fifo_read) fifo_data <= mem[nread[2:0]];
  end

  always @(posedge clk) begin
    if (reset) mcnt <= 4'd0;
    else       mcnt <= mcnt + 4'd1;
  end

  typedef struct {
    logic        ch;
    logic        dir;
    logic [10:0] a_in;
    logic [10:0] a_out;
    logic [63:0] bytes;
    logic        go;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;

  vec_t vt [9];
  int   tests = 0, fails = 0;
  int   m_under = 0, m_err = 0, m_streak = 0;
  logic [31:0] m_sample = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic word_model(input logic [31:0] w);
    m_sample = w;
`ifdef DUMMY_DAC_CHECK_EN
    if (w != 32'hDEADBEEF) begin
      m_streak = 0;
      if (m_err < 65535) m_err++;
    end else if (m_streak < 4) begin
      m_streak++;
    end
`endif
  endtask

  function automatic logic [15:0] exp_err();
`ifdef DUMMY_DAC_CHECK_EN
    return 16'(m_err);
`else
    return 16'h0;
`endif
  endfunction

  function automatic logic exp_lock();
`ifdef DUMMY_DAC_CHECK_EN
    return m_streak == 4;
`else
    return 1'b0;
`endif
  endfunction

  task automatic wait_tick();
    for (int n = 0; n < 40 && mcnt != 4'd15; n++) @(negedge clk);
    chk("tick_reached", 32'(mcnt), 32'd15);
  endtask

  task automatic setup(input logic [10:0] a_in, input logic [10:0] a_out,
                       input logic ch, input logic dir, input logic [63:0] b);
    for (int k = 0; k < 8; k++) mem[k] = b[8*k +: 8];
    base_out     = a_out;
    fifo_addr_in = a_in;
    channels     = ch;
    direction    = dir;
    clr          = 1'b1;
    @(negedge clk);
    clr          = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rd"},     32'(fifo_read),      32'd0);
    chk({tag, "_sv"},     32'(sample_valid),   32'd0);
    chk({tag, "_sample"}, sample,              32'd0);
    chk({tag, "_under"},  32'(underrun_count), 32'd0);
    chk({tag, "_err"},    32'(error_count),    32'd0);
    chk({tag, "_lock"},   32'(locked),         32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int    need;
    logic  e_rd, e_sv;
    logic [31:0] w;
    setup(v.a_in, v.a_out, v.ch, v.dir, v.bytes);
    wait_tick();
    need = v.ch ? 8 : 4;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      e_rd = v.go && (c <= need);
      e_sv = v.go && (c == 6 || (v.ch && c == 10));
      chk($sformatf("v%0d_rd_T+%0d", idx, c), 32'(fifo_read), 32'(e_rd));
      chk($sformatf("v%0d_sv_T+%0d", idx, c), 32'(sample_valid), 32'(e_sv));
      if (e_sv) begin
        w = (c == 6) ? v.w0 : v.w1;
        word_model(w);
        chk($sformatf("v%0d_sample_T+%0d", idx, c), sample, w);
        chk($sformatf("v%0d_err_T+%0d", idx, c), 32'(error_count), 32'(exp_err()));
        chk($sformatf("v%0d_lock_T+%0d", idx, c), 32'(locked), 32'(exp_lock()));
      end
    end
    if (!v.go && !v.dir) m_under++;
    chk($sformatf("v%0d_under", idx), 32'(underrun_count), 32'(m_under));
    chk($sformatf("v%0d_hold", idx), sample, m_sample);
  endtask

  initial begin
    vt[0] = '{1'b0, 1'b0, 11'd4, 11'd0,    64'h00000000_DEADBEEF, 1'b1, 32'hDEADBEEF, 32'h0};
    vt[1] = '{1'b0, 1'b0, 11'd3, 11'd0,    64'h00000000_DEADBEEF, 1'b0, 32'h0, 32'h0};
    vt[2] = '{1'b1, 1'b0, 11'd8, 11'd0,    64'h88776655_44332211, 1'b1, 32'h44332211, 32'h88776655};
    vt[3] = '{1'b0, 1'b0, 11'd2, 11'd2046, 64'h00000000_DEADBEEF, 1'b1, 32'hDEADBEEF, 32'h0};
    vt[4] = '{1'b0, 1'b1, 11'd4, 11'd0,    64'h00000000_DEADBEEF, 1'b0, 32'h0, 32'h0};
    vt[5] = '{1'b1, 1'b0, 11'd7, 11'd0,    64'hDEADBEEF_DEADBEEF, 1'b0, 32'h0, 32'h0};
    vt[6] = '{1'b0, 1'b0, 11'd4, 11'd0,    64'h00000000_DEADBEEF, 1'b1, 32'hDEADBEEF, 32'h0};
    vt[7] = '{1'b1, 1'b0, 11'd8, 11'd0,    64'hDEADBEEF_DEADBEEF, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF};
    vt[8] = '{1'b0, 1'b0, 11'd4, 11'd0,    64'h00000000_00000000, 1'b1, 32'h00000000, 32'h0};

    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(vt[i], i);

    // Saturation: preload near the top, then keep the FIFO empty across several ticks
    setup(11'd0, 11'd0, 1'b0, 1'b0, 64'h0);
    force dut.underrun_count = 16'hFFFE;
    #1 release dut.underrun_count;
    wait_tick();
    @(negedge clk);
    chk("sat_first", 32'(underrun_count), 32'hFFFF);
    for (int t = 0; t < 3; t++) begin
      wait_tick();
      @(negedge clk);
    end
    chk("sat_hold", 32'(underrun_count), 32'hFFFF);
    chk("sat_no_read", 32'(fifo_read), 32'd0);

    // Reset in the middle of a mono transfer
    setup(11'd4, 11'd0, 1'b0, 1'b0, 64'h00000000_DEADBEEF);
    wait_tick();
    repeat (3) @(negedge clk);
    chk("mid_rd_T+3", 32'(fifo_read), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_zero("mid_T+4");
    reset = 1'b0;
    for (int c = 5; c <= 10; c++) begin
      @(negedge clk);
      chk($sformatf("mid_sv_T+%0d", c), 32'(sample_valid), 32'd0);
      chk($sformatf("mid_rd_T+%0d", c), 32'(fifo_read), 32'd0);
    end
    chk("mid_sample", sample, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
